delay_ctrl: RTL

Memory-mapped delay controller inside `soc_system`, sitting directly upstream of `blinker`. It holds the blink-delay value driven to `blinker`, steps that value in response to the one-shot key pulses (`slower`/`faster`), and exposes the value, status, control and step size to the HPS over an Avalon-MM slave with fixed read latency 1. A button-induced change raises an optional interrupt so software can track front-panel adjustments.

---
 rtl/delay_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/delay_ctrl.sv
// delay_ctrl: memory-mapped blink-delay controller.
// Holds the delay value driven to the blinker and steps it on one-shot key
// pulses. Exposes delay, status, control and step size over an Avalon-MM
// slave with a fixed read latency of 1.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   avs_address[1:0]      word address (0 DELAY, 1 STATUS, 2 CTRL, 3 STEP)
//   avs_read / avs_write  access strobes, no waitrequest
//   avs_writedata[31:0]   write data
//   avs_readdata[31:0]    registered read data, holds between reads
//   avs_readdatavalid     high one cycle after each accepted read
//   slower / faster       single-cycle pulses: step delay up / down
//   delay[DELAY_WIDTH-1:0] current delay to the blinker
//   irq                   level interrupt (pending & irq_en)
module delay_ctrl #(
  parameter int unsigned DELAY_WIDTH   = 4,
  parameter int unsigned DEFAULT_DELAY = 8,
  parameter int unsigned MIN_DELAY     = 0,
  parameter int unsigned MAX_DELAY     = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             avs_address,
  input  logic                   avs_read,
  input  logic                   avs_write,
  input  logic [31:0]            avs_writedata,
  output logic [31:0]            avs_readdata,
  output logic                   avs_readdatavalid,
  input  logic                   slower,
  input  logic                   faster,
  output logic [DELAY_WIDTH-1:0] delay,
  output logic                   irq
);

  localparam int unsigned DW  = DELAY_WIDTH;
  localparam int unsigned SW  = DELAY_WIDTH + 1;  // unsigned sum width
  localparam int unsigned DFW = DELAY_WIDTH + 2;  // signed difference width
  localparam int unsigned CW  = 8;                // step counter width

  localparam logic [1:0] ADDR_DELAY  = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STEP   = 2'd3;

  logic [DW-1:0] delay_q, delay_d;
  logic [DW-1:0] step_q, step_d;
  logic          irq_en_q, irq_en_d;
  logic          lock_q, lock_d;
  logic          pending_q, pending_d;
  logic [CW-1:0] step_count_q, step_count_d;
  logic [31:0]   readdata_q, readdata_d;
  logic          rdv_q, rdv_d;
  logic          irq_q, irq_d;

  logic                  at_min_c, at_max_c;
  logic                  wr_delay_c, w1c_c;
  logic                  btn_req_c, btn_chg_c;
  logic [SW-1:0]         sum_c;
  logic signed [DFW-1:0] diff_c;
  logic [DW-1:0]         btn_val_c;

  assign at_min_c = (delay_q == DW'(MIN_DELAY));
  assign at_max_c = (delay_q == DW'(MAX_DELAY));

  // Button step: saturating add/subtract at widened precision, never wraps.
  always_comb begin
    sum_c     = {1'b0, delay_q} + {1'b0, step_q};
    diff_c    = $signed({2'b00, delay_q}) - $signed({2'b00, step_q});
    btn_val_c = delay_q;
    if (slower) begin
      btn_val_c = (sum_c >= SW'(MAX_DELAY)) ? DW'(MAX_DELAY) : sum_c[DW-1:0];
    end else begin
      btn_val_c = (diff_c <= $signed(DFW'(MIN_DELAY))) ? DW'(MIN_DELAY)
                                                      : diff_c[DW-1:0];
    end
  end

  // A DELAY write in the same cycle discards the pulse; both keys cancel.
  assign wr_delay_c = avs_write && (avs_address == ADDR_DELAY);
  assign w1c_c      = avs_write && (avs_address == ADDR_STATUS) && avs_writedata[0];
  assign btn_req_c  = !lock_q && (slower ^ faster) && !wr_delay_c;
  assign btn_chg_c  = btn_req_c && (btn_val_c != delay_q);

  // Register next-state: writes, button update, read capture, irq.
  always_comb begin
    delay_d      = delay_q;
    step_d       = step_q;
    irq_en_d     = irq_en_q;
    lock_d       = lock_q;
    step_count_d = step_count_q;
    readdata_d   = readdata_q;
    rdv_d        = avs_read;

    if (avs_write) begin
      case (avs_address)
        ADDR_DELAY: begin
          // Clamp on the full written word so out-of-range values saturate.
          if (avs_writedata >= 32'(MAX_DELAY)) begin
            delay_d = DW'(MAX_DELAY);
          end else if (avs_writedata <= 32'(MIN_DELAY)) begin
            delay_d = DW'(MIN_DELAY);
          end else begin
            delay_d = avs_writedata[DW-1:0];
          end
        end
        ADDR_CTRL: begin
          irq_en_d = avs_writedata[0];
          lock_d   = avs_writedata[1];
        end
        ADDR_STEP: begin
          step_d = (avs_writedata[DW-1:0] == '0) ? DW'(1) : avs_writedata[DW-1:0];
        end
        default: ;
      endcase
    end

    if (btn_chg_c) begin
      delay_d      = btn_val_c;
      step_count_d = step_count_q + CW'(1);
    end

    // Set beats a coincident write-1-to-clear.
    pending_d = btn_chg_c | (pending_q & ~w1c_c);
    irq_d     = pending_d & irq_en_d;

    // Reads return state as it was before this cycle's update.
    if (avs_read) begin
      case (avs_address)
        ADDR_DELAY:  readdata_d = 32'(delay_q);
        ADDR_STATUS: readdata_d = {16'h0, step_count_q, 5'h0, at_max_c, at_min_c, pending_q};
        ADDR_CTRL:   readdata_d = {30'h0, lock_q, irq_en_q};
        default:     readdata_d = 32'(step_q);
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      delay_q      <= DW'(DEFAULT_DELAY);
      step_q       <= DW'(1);
      irq_en_q     <= 1'b0;
      lock_q       <= 1'b0;
      pending_q    <= 1'b0;
      step_count_q <= '0;
      readdata_q   <= '0;
      rdv_q        <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      delay_q      <= delay_d;
      step_q       <= step_d;
      irq_en_q     <= irq_en_d;
      lock_q       <= lock_d;
      pending_q    <= pending_d;
      step_count_q <= step_count_d;
      readdata_q   <= readdata_d;
      rdv_q        <= rdv_d;
      irq_q        <= irq_d;
    end
  end

  assign delay             = delay_q;
  assign irq               = irq_q;
  assign avs_readdata      = readdata_q;
  assign avs_readdatavalid = rdv_q;

endmodule
